// File: rtl/SequencerParams.sv
// Shared constants for the register-operand sequencer: state encoding,
// register-file memory-operation codes, addressing modes and special registers.
package SequencerParams;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_SRC_EXT = 4'd2,
    S_SRC_RD  = 4'd3,
    S_DST_EXT = 4'd4,
    S_DST_RD  = 4'd5,
    S_PUSH    = 4'd6,
    S_EXEC    = 4'd7,
    S_WB      = 4'd8
  } seq_state_t;

  typedef enum logic [1:0] {
    MO_NOP        = 2'd0,
    MO_NEXT_INSTR = 2'd1,
    MO_OFFSET     = 2'd2,
    MO_SP_PREDEC  = 2'd3
  } mo_t;

  localparam logic [1:0] AS_REG       = 2'b00;
  localparam logic [1:0] AS_INDEXED   = 2'b01;
  localparam logic [1:0] AS_INDIRECT  = 2'b10;
  localparam logic [1:0] AS_INDIR_INC = 2'b11;

  localparam logic AD_REG     = 1'b0;
  localparam logic AD_INDEXED = 1'b1;

  localparam logic [3:0] PC  = 4'd0;
  localparam logic [3:0] SP  = 4'd1;
  localparam logic [3:0] SR  = 4'd2;
  localparam logic [3:0] CG1 = 4'd2;
  localparam logic [3:0] CG2 = 4'd3;

  // Operand fields captured when an instruction is accepted.
  typedef struct packed {
    logic [3:0] src;
    logic [3:0] dst;
    logic [1:0] as_mode;
    logic       ad;
    logic       one_op;
    logic       push;
    logic       jump;
  } instr_fields_t;

  // @PC+ is the immediate form: the operand is the extension word itself.
  function automatic logic is_immediate(input logic [1:0] mode, input logic [3:0] rn);
    return (mode == AS_INDIR_INC) && (rn == PC);
  endfunction

endpackage

// File: rtl/reg_seq_moddec.sv
// Addressing-mode decoder: which extension-word and operand-read states an
// instruction needs. SEQ_CG_BYPASS_EN lets constant-generator sources skip both.
module reg_seq_moddec
  import SequencerParams::*;
(
  input  instr_fields_t fld,
  output logic          srcExt,
  output logic          srcRd,
  output logic          dstExt,
  output logic          dstRd,
  output logic          isCG
);

  logic src_imm;
  logic dst_imm;
  logic src_ext_raw;
  logic src_rd_raw;

  assign src_imm = is_immediate(fld.as_mode, fld.src);
  assign dst_imm = is_immediate(fld.as_mode, fld.dst);
  assign isCG    = (fld.src == CG2) || ((fld.src == CG1) && fld.as_mode[1]);

  // Single-operand instructions carry their operand in the destination slot.
  assign src_ext_raw = !fld.one_op && ((fld.as_mode == AS_INDEXED) || src_imm);
  assign src_rd_raw  = !fld.one_op && (fld.as_mode != AS_REG) && !src_imm;

`ifdef SEQ_CG_BYPASS_EN
  assign srcExt = src_ext_raw && !isCG;
  assign srcRd  = src_rd_raw && !isCG;
`else
  assign srcExt = src_ext_raw;
  assign srcRd  = src_rd_raw;
`endif

  assign dstExt = fld.one_op ? ((fld.as_mode == AS_INDEXED) || dst_imm) : fld.ad;
  assign dstRd  = fld.one_op ? ((fld.as_mode != AS_REG) && !dst_imm) : fld.ad;

endmodule

// File: rtl/reg_sequencer.sv
// Register-file operand sequencer: Moore FSM stepping fetch, extension words,
// operand reads, SP pre-decrement, execute and write-back. Option: SEQ_CG_BYPASS_EN.
module reg_sequencer
  import SequencerParams::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] srcA,
  input  logic [3:0] dstA,
  input  logic [1:0] As,
  input  logic       Ad,
  input  logic       OneOp,
  input  logic       push,
  input  logic       jump,
  input  logic       mem_rdy,
  output logic [1:0] MO,
  output logic       incSrc,
  output logic       incDst,
  output logic       indirect,
  output logic       RW,
  output logic [3:0] resultA,
  output logic       SRW,
  output logic       busy
);

  seq_state_t    state;
  seq_state_t    state_nxt;
  instr_fields_t fld;

  logic src_ext;
  logic src_rd;
  logic dst_ext;
  logic dst_rd;
  logic is_cg;
  logic cg_unused;

  seq_state_t after_fetch;
  seq_state_t after_src_ext;
  seq_state_t after_src_rd;
  seq_state_t after_dst_ext;
  seq_state_t after_dst_rd;

  reg_seq_moddec u_moddec (
    .fld    (fld),
    .srcExt (src_ext),
    .srcRd  (src_rd),
    .dstExt (dst_ext),
    .dstRd  (dst_rd),
    .isCG   (is_cg)
  );

  // The bypass is applied inside the decoder; the flag itself is only a debug tap here.
  assign cg_unused = is_cg;

  // State advances on the falling edge so the decoded controls settle before the register file's rising edge.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      fld <= '0;
    end else if ((state == S_IDLE) && instr_valid) begin
      fld <= {srcA, dstA, As, Ad, OneOp, push, jump};
    end
  end

  // Each state's successor is the first still-required state further down the sequence.
  assign after_dst_rd  = fld.push ? S_PUSH : S_EXEC;
  assign after_dst_ext = dst_rd ? S_DST_RD : after_dst_rd;
  assign after_src_rd  = dst_ext ? S_DST_EXT : after_dst_ext;
  assign after_src_ext = src_rd ? S_SRC_RD : after_src_rd;
  assign after_fetch   = fld.jump ? S_EXEC : (src_ext ? S_SRC_EXT : after_src_ext);

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    MO          = MO_NOP;
    incSrc      = 1'b0;
    incDst      = 1'b0;
    indirect    = 1'b0;
    RW          = 1'b0;
    resultA     = 4'd0;
    SRW         = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        MO        = MO_NEXT_INSTR;
        state_nxt = after_fetch;
      end
      S_SRC_EXT: begin
        MO = MO_OFFSET;
        if (mem_rdy) state_nxt = after_src_ext;
      end
      S_SRC_RD: begin
        indirect = 1'b1;
        incSrc   = (fld.as_mode == AS_INDIR_INC) && !fld.one_op;
        if (mem_rdy) state_nxt = after_src_rd;
      end
      S_DST_EXT: begin
        MO = MO_OFFSET;
        if (mem_rdy) state_nxt = after_dst_ext;
      end
      S_DST_RD: begin
        indirect = 1'b1;
        incDst   = (fld.as_mode == AS_INDIR_INC) && fld.one_op;
        if (mem_rdy) state_nxt = after_dst_rd;
      end
      S_PUSH: begin
        MO = MO_SP_PREDEC;
        if (mem_rdy) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        SRW       = !fld.jump;
        state_nxt = fld.jump ? S_IDLE : S_WB;
      end
      S_WB: begin
        RW        = fld.one_op ? (fld.as_mode == AS_REG) : (fld.ad == AD_REG);
        resultA   = RW ? fld.dst : 4'd0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_reg_sequencer.sv
// Table-driven bench for reg_sequencer: per-cycle expected controls are queued
// when an instruction is issued and compared at each rising edge.
module tb_reg_sequencer;

  logic       clk;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] srcA;
  logic [3:0] dstA;
  logic [1:0] As;
  logic       Ad;
  logic       OneOp;
  logic       push;
  logic       jump;
  logic       mem_rdy;
  logic [1:0] MO;
  logic       incSrc;
  logic       incDst;
  logic       indirect;
  logic       RW;
  logic [3:0] resultA;
  logic       SRW;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Per-cycle code: {MO[1:0], indirect, incSrc, incDst, SRW, RW}
  localparam logic [6:0] Z      = 7'b00_00000;
  localparam logic [6:0] C_NI   = 7'b01_00000;
  localparam logic [6:0] C_OFF  = 7'b10_00000;
  localparam logic [6:0] C_SPD  = 7'b11_00000;
  localparam logic [6:0] C_IND  = 7'b00_10000;
  localparam logic [6:0] C_INDS = 7'b00_11000;
  localparam logic [6:0] C_INDD = 7'b00_10100;
  localparam logic [6:0] C_EXEC = 7'b00_00010;
  localparam logic [6:0] C_WBR  = 7'b00_00001;

  typedef struct {
    string      name;
    logic [3:0] src;
    logic [3:0] dst;
    logic [1:0] as_m;
    logic       ad;
    logic       one;
    logic       psh;
    logic       jmp;
    int         n;
    logic [6:0] cyc [8];
    logic [3:0] resa;
  } vec_t;

  typedef struct {
    string       tag;
    logic [12:0] v;
    logic        mr;
  } exp_t;

  vec_t tbl [10];
  exp_t sb [$];
  logic hold_valid;

  reg_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .srcA        (srcA),
    .dstA        (dstA),
    .As          (As),
    .Ad          (Ad),
    .OneOp       (OneOp),
    .push        (push),
    .jump        (jump),
    .mem_rdy     (mem_rdy),
    .MO          (MO),
    .incSrc      (incSrc),
    .incDst      (incDst),
    .indirect    (indirect),
    .RW          (RW),
    .resultA     (resultA),
    .SRW         (SRW),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] obs();
    return {instr_ready, busy, MO, indirect, incSrc, incDst, SRW, RW, resultA};
  endfunction

  function automatic logic [12:0] mk(input logic bsy, input logic [6:0] c, input logic [3:0] ra);
    return {~bsy, bsy, c[6:5], c[4], c[3], c[2], c[1], c[0], (c[0] ? ra : 4'd0)};
  endfunction

  task automatic chk(input string tag, input logic [12:0] exp);
    logic [12:0] got;
    got = obs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got={rdy,busy,MO,ind,incS,incD,SRW,RW,resA}=%b required=%b", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic bsy, input logic [6:0] c,
                          input logic [3:0] ra, input logic mr);
    exp_t e;
    e.tag = tag;
    e.v   = mk(bsy, c, ra);
    e.mr  = mr;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      @(posedge clk);
      e = sb.pop_front();
      chk(e.tag, e.v);
      mem_rdy     = e.mr;
      instr_valid = hold_valid && (sb.size() > 1);
    end
  endtask

  // With hold set, instr_valid stays high with scrambled fields until WB to show they are ignored.
  task automatic issue(input logic [3:0] s, input logic [3:0] d, input logic [1:0] a,
                       input logic ad, input logic one, input logic ps, input logic jp,
                       input bit hold);
    srcA = s; dstA = d; As = a; Ad = ad; OneOp = one; push = ps; jump = jp;
    instr_valid = 1'b1;
    hold_valid  = hold;
    @(negedge clk);
    #1;
    if (hold) begin
      srcA = ~s; dstA = 4'hF; As = ~a; Ad = ~ad;
    end else begin
      instr_valid = 1'b0;
    end
  endtask

  task automatic run_vec(input int k, input bit hold);
    for (int i = 0; i < tbl[k].n; i++)
      push_exp($sformatf("%s c%0d", tbl[k].name, i), 1'b1, tbl[k].cyc[i], tbl[k].resa, 1'b1);
    push_exp({tbl[k].name, " idle"}, 1'b0, Z, 4'd0, 1'b1);
    issue(tbl[k].src, tbl[k].dst, tbl[k].as_m, tbl[k].ad, tbl[k].one, tbl[k].psh,
          tbl[k].jmp, hold);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; instr_valid = 1'b0; mem_rdy = 1'b1; hold_valid = 1'b0;
    srcA = 4'd0; dstA = 4'd0; As = 2'd0; Ad = 1'b0; OneOp = 1'b0; push = 1'b0; jump = 1'b0;

    tbl[0] = '{"MOV R5,R7", 4'd5, 4'd7, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3,
               '{C_NI, C_EXEC, C_WBR, Z, Z, Z, Z, Z}, 4'd7};
    tbl[1] = '{"MOV @R6+,R11", 4'd6, 4'd11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4,
               '{C_NI, C_INDS, C_EXEC, C_WBR, Z, Z, Z, Z}, 4'd11};
    tbl[2] = '{"ADD #imm,8(R10)", 4'd0, 4'd10, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 6,
               '{C_NI, C_OFF, C_OFF, C_IND, C_EXEC, Z, Z, Z}, 4'd10};
    tbl[3] = '{"PUSH R5", 4'd5, 4'd5, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 4,
               '{C_NI, C_SPD, C_EXEC, C_WBR, Z, Z, Z, Z}, 4'd5};
    tbl[4] = '{"JMP", 4'd0, 4'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2,
               '{C_NI, Z, Z, Z, Z, Z, Z, Z}, 4'd3};
    tbl[5] = '{"RRA @R9+", 4'd4, 4'd9, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 4,
               '{C_NI, C_INDD, C_EXEC, Z, Z, Z, Z, Z}, 4'd9};
    tbl[6] = '{"MOV 4(R5),R6", 4'd5, 4'd6, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 5,
               '{C_NI, C_OFF, C_IND, C_EXEC, C_WBR, Z, Z, Z}, 4'd6};
    tbl[7] = '{"MOV R4,2(R8)", 4'd4, 4'd8, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 5,
               '{C_NI, C_OFF, C_IND, C_EXEC, Z, Z, Z, Z}, 4'd8};
`ifdef SEQ_CG_BYPASS_EN
    tbl[8] = '{"MOV #2,R4", 4'd3, 4'd4, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 3,
               '{C_NI, C_EXEC, C_WBR, Z, Z, Z, Z, Z}, 4'd4};
`else
    tbl[8] = '{"MOV #2,R4", 4'd3, 4'd4, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 4,
               '{C_NI, C_IND, C_EXEC, C_WBR, Z, Z, Z, Z}, 4'd4};
`endif
    tbl[9] = '{"PUSH #imm", 4'd0, 4'd0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 5,
               '{C_NI, C_OFF, C_SPD, C_EXEC, Z, Z, Z, Z}, 4'd0};

    repeat (2) @(posedge clk);
    chk("reset_held", mk(1'b0, Z, 4'd0));
    #1 reset = 1'b1;
    @(posedge clk);
    chk("after_reset", mk(1'b0, Z, 4'd0));

    for (int k = 0; k < 10; k++) run_vec(k, (k == 0));

    // SRC_RD held for three cycles by two cycles of mem_rdy low.
    push_exp("hold FETCH", 1'b1, C_NI, 4'd11, 1'b1);
    push_exp("hold SRC_RD a", 1'b1, C_INDS, 4'd11, 1'b0);
    push_exp("hold SRC_RD b", 1'b1, C_INDS, 4'd11, 1'b0);
    push_exp("hold SRC_RD c", 1'b1, C_INDS, 4'd11, 1'b1);
    push_exp("hold EXEC", 1'b1, C_EXEC, 4'd11, 1'b1);
    push_exp("hold WB", 1'b1, C_WBR, 4'd11, 1'b1);
    push_exp("hold idle", 1'b0, Z, 4'd0, 1'b1);
    issue(4'd6, 4'd11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Jump, then abort the next instruction from inside SRC_EXT.
    run_vec(4, 1'b0);
    push_exp("abort FETCH", 1'b1, C_NI, 4'd0, 1'b1);
    push_exp("abort SRC_EXT", 1'b1, C_OFF, 4'd0, 1'b1);
    issue(4'd5, 4'd6, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    #2 reset = 1'b0;
    #1 chk("reset_async", mk(1'b0, Z, 4'd0));
    @(posedge clk);
    chk("reset_low", mk(1'b0, Z, 4'd0));
    #1 reset = 1'b1;
    @(posedge clk);
    chk("reset_release", mk(1'b0, Z, 4'd0));
    run_vec(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
